enemy_base_manager: RTL and testbench
=====================================

// Module: enemy_base_manager
// PURPOSE
//  Owns the lifecycle of all enemy bases: ALIVE -> EXPLODING -> DEAD (-> ALIVE on respawn).
//  Time-shares one bullet-vs-base window comparator across N_BASES bases, once per frame.
//  Returns per-bullet kill pulses to the bullet logic and drives score and all-cleared.
//  Sits between the bullet controller and the sprite renderer and score display.
// PARAMETERS
//  N_BASES         4    number of enemy bases scanned per frame
//  HIT_HALF        5    half-width of hit window around base centre, inclusive, in pixels
//  CTR_OFF_X       32   base centre X offset from top-left corner (base width 64)
//  CTR_OFF_Y       36   base centre Y offset from top-left corner (base height 72)
//  EXPLODE_FRAMES  16   number of frames a base spends in EXPLODING
//  RESPAWN_FRAMES  0    number of frames in DEAD before ALIVE again; 0 = never respawn
//  SCORE_PER_BASE  10   amount added to score per destroyed base
// PORTS
//  Clk             in   1        system clock
//  Reset_n         in   1        asynchronous reset, active-low
//  frame_tick      in   1        1-cycle strobe per video frame, synchronous to Clk
//  base_tl_x       in   10*N     packed top-left X coordinates; base i at [10*i +: 10]
//  base_tl_y       in   10*N     packed top-left Y coordinates
//  bullet_x        in   20       bullet 0 at [9:0], bullet 1 at [19:10]
//  bullet_y        in   20       same packing as bullet_x
//  bullet_valid    in   2        bullet is in flight
//  bullet_kill     out  2        1-cycle pulse: bullet consumed by a hit
//  base_alive      out  N        base is ALIVE (collidable, drawn normally)
//  base_exploding  out  N        base is EXPLODING (draw explosion sprite)
//  score           out  16       accumulated score, saturating
//  all_cleared     out  1        no base is ALIVE or EXPLODING
//  scan_busy       out  1        scan in progress
//  tick_overrun    out  1        sticky: frame_tick arrived while not IDLE
// BEHAVIOUR
//  Reset state: all bases ALIVE, timers 0. Outputs: base_alive all ones, base_exploding 0,
//  score 0, bullet_kill 0, all_cleared 0, scan_busy 0, tick_overrun 0.
//  FSM IDLE/SCAN/UPDATE.
//  - IDLE + frame_tick at cycle T: capture bullet_x/y/valid into snapshot; SCAN at T+1.
//  - SCAN: one base per cycle, idx 0..N-1; base idx is evaluated at cycle T+1+idx.
//    After idx N-1 the FSM goes to UPDATE. UPDATE lasts 1 cycle, then IDLE.
//  - scan_busy = (state != IDLE).
//  - frame_tick outside IDLE is ignored and sets tick_overrun. Only reset clears tick_overrun.
//  Hit test:
//  - Only for ALIVE bases and snapshot bullets that are valid and not yet consumed.
//  - Centre is base_tl + CTR_OFF, computed in 11 bits, so no wrap at 1023.
//  - A hit needs |bx-cx| <= HIT_HALF AND |by-cy| <= HIT_HALF, with both bounds inclusive.
//  - Window edges are clamped at 0; there is no underflow for a centre < HIT_HALF.
//  On a hit to base idx:
//  - The base goes to EXPLODING with timer = EXPLODE_FRAMES.
//  - Each hitting bullet's bullet_kill pulses at the next cycle and is marked consumed.
//  - A consumed bullet cannot hit a later base in the same scan, so the lowest index wins.
//  - If both bullets hit the same base: both are killed and score is added once.
//  - score += SCORE_PER_BASE in the same cycle as the hit, saturating at 16'hFFFF.
//  UPDATE cycle, per base:
//  - EXPLODING: the timer decrements; if the timer was 1 the base goes to DEAD.
//    If RESPAWN_FRAMES == 0 the base stays DEAD permanently; otherwise timer = RESPAWN_FRAMES.
//  - DEAD: the timer decrements; at 1 the base goes to ALIVE.
//  - Bases hit in this scan are not decremented in the same UPDATE.
//  Output timing:
//  - base_alive, base_exploding and all_cleared are registered and update the cycle after any state change.
//  Reset mid-scan: everything returns to reset values immediately, with no pending kill pulse.
// STRUCTURE
//  Package enemy_base_pkg:
//  - base_state_t enum {BASE_ALIVE, BASE_EXPLODING, BASE_DEAD}
//  - mgr_state_t enum {MGR_IDLE, MGR_SCAN, MGR_UPDATE}
//  - localparam COORD_W = 10
//  Sub-module base_hit_window: combinational inputs tl_x, tl_y, bx, by, valid -> hit.
//  - It contains the centre offset, clamping and the inclusive compare.
//  - One instance per bullet (two total), fed by the base index mux.
//  Timer width is $clog2(max(EXPLODE_FRAMES, RESPAWN_FRAMES) + 1).
// TESTING
//  1. Reset, then base0 tl = (100,100) and bullet0 = (132,136) valid, then frame_tick.
//     -> bullet_kill[0] pulses once at T+2, base_exploding[0] = 1, score = 10.
//  2. Edge of window: bullet at (137,141) -> hit; bullet at (138,136) -> no hit and no score change.
//  3. base1 and base2 share a centre; bullet0 is on that centre.
//     -> only base1 explodes; a single kill pulse; score = 10.
//  4. Both bullets on base0 centre -> bullet_kill = 2'b11 in the same cycle; score = 10.
//  5. Hit base0, then give 16 further frame_ticks -> base_exploding[0] falls after UPDATE of the 16th.
//     With RESPAWN_FRAMES = 0 it stays dead. Killing all N bases -> all_cleared = 1 after the last explosion.
//  6. Reset_n low mid-SCAN -> immediate reset values.
//     Also: frame_tick during SCAN -> tick_overrun = 1 and no extra scan; score preset near 16'hFFF8 saturates at FFFF.

Source files
------------

// File: rtl/enemy_base_pkg.sv
// Shared types and constants for the enemy base manager and its hit-window comparator.
package enemy_base_pkg;

  typedef enum logic [1:0] {BASE_ALIVE, BASE_EXPLODING, BASE_DEAD} base_state_t;
  typedef enum logic [1:0] {MGR_IDLE, MGR_SCAN, MGR_UPDATE} mgr_state_t;

  localparam int COORD_W = 10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/enemy_base_manager_hit_window.sv
// Combinational bullet-vs-base window test: centre offset, zero-clamped low edge, inclusive bounds.
module base_hit_window
  import enemy_base_pkg::*;
#(
  parameter int HIT_HALF  = 5,
  parameter int CTR_OFF_X = 32,
  parameter int CTR_OFF_Y = 36
) (
  input  logic [COORD_W-1:0] tl_x,
  input  logic [COORD_W-1:0] tl_y,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic               valid,
  output logic               hit
);

  localparam int W = COORD_W + 1;

  // One extra bit so a base near the right/bottom edge does not wrap its centre.
  logic [W-1:0] cx, cy, x_lo, x_hi, y_lo, y_hi;

  assign cx   = {1'b0, tl_x} + W'(CTR_OFF_X);
  assign cy   = {1'b0, tl_y} + W'(CTR_OFF_Y);
  assign x_lo = (cx >= W'(HIT_HALF)) ? (cx - W'(HIT_HALF)) : '0;
  assign y_lo = (cy >= W'(HIT_HALF)) ? (cy - W'(HIT_HALF)) : '0;
  assign x_hi = cx + W'(HIT_HALF);
  assign y_hi = cy + W'(HIT_HALF);

  assign hit = valid
             && ({1'b0, bx} >= x_lo) && ({1'b0, bx} <= x_hi)
             && ({1'b0, by} >= y_lo) && ({1'b0, by} <= y_hi);

endmodule

// File: rtl/enemy_base_manager.sv
// Enemy base lifecycle owner: scans one base per cycle after each frame tick, then ages timers.
module enemy_base_manager
  import enemy_base_pkg::*;
#(
  parameter int          N_BASES        = 4,
  parameter int          HIT_HALF       = 5,
  parameter int          CTR_OFF_X      = 32,
  parameter int          CTR_OFF_Y      = 36,
  parameter int          EXPLODE_FRAMES = 16,
  parameter int          RESPAWN_FRAMES = 0,
  parameter logic [15:0] SCORE_PER_BASE = 16'd10,
  parameter logic [15:0] SCORE_INIT     = 16'd0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_tick,
  input  logic [COORD_W*N_BASES-1:0] base_tl_x,
  input  logic [COORD_W*N_BASES-1:0] base_tl_y,
  input  logic [19:0]                bullet_x,
  input  logic [19:0]                bullet_y,
  input  logic [1:0]                 bullet_valid,
  output logic [1:0]                 bullet_kill,
  output logic [N_BASES-1:0]         base_alive,
  output logic [N_BASES-1:0]         base_exploding,
  output logic [15:0]                score,
  output logic                       all_cleared,
  output logic                       scan_busy,
  output logic                       tick_overrun
);

  localparam int TW = $clog2(max2(EXPLODE_FRAMES, RESPAWN_FRAMES) + 1);
  localparam int IW = (N_BASES > 1) ? $clog2(N_BASES) : 1;

  mgr_state_t   mgr;
  logic [IW-1:0] idx;
  logic [19:0]  snap_x, snap_y;
  logic [1:0]   snap_v, consumed, hits;
  logic [N_BASES-1:0] hit_mask, alive_nx, expl_nx;
  base_state_t  bst    [N_BASES];
  base_state_t  bst_nx [N_BASES];
  logic [TW-1:0] tmr    [N_BASES];
  logic [TW-1:0] tmr_nx [N_BASES];
  logic [COORD_W-1:0] cur_x, cur_y;
  logic         cur_ok;
  logic [16:0]  score_sum;

  assign cur_x     = base_tl_x[idx*COORD_W +: COORD_W];
  assign cur_y     = base_tl_y[idx*COORD_W +: COORD_W];
  assign cur_ok    = (mgr == MGR_SCAN) && (bst[idx] == BASE_ALIVE);
  assign score_sum = {1'b0, score} + {1'b0, SCORE_PER_BASE};
  assign scan_busy = (mgr != MGR_IDLE);

  base_hit_window #(.HIT_HALF(HIT_HALF), .CTR_OFF_X(CTR_OFF_X), .CTR_OFF_Y(CTR_OFF_Y)) u_hit0 (
    .tl_x(cur_x), .tl_y(cur_y), .bx(snap_x[9:0]), .by(snap_y[9:0]),
    .valid(cur_ok && snap_v[0] && !consumed[0]), .hit(hits[0])
  );

  base_hit_window #(.HIT_HALF(HIT_HALF), .CTR_OFF_X(CTR_OFF_X), .CTR_OFF_Y(CTR_OFF_Y)) u_hit1 (
    .tl_x(cur_x), .tl_y(cur_y), .bx(snap_x[19:10]), .by(snap_y[19:10]),
    .valid(cur_ok && snap_v[1] && !consumed[1]), .hit(hits[1])
  );

  always_comb begin
    bst_nx = bst;
    tmr_nx = tmr;
    if (mgr == MGR_SCAN && (|hits)) begin
      bst_nx[idx] = BASE_EXPLODING;
      tmr_nx[idx] = TW'(EXPLODE_FRAMES);
    end
    if (mgr == MGR_UPDATE) begin
      for (int i = 0; i < N_BASES; i++) begin
        if (!hit_mask[i]) begin
          // A DEAD base with a zero timer never respawns.
          if (bst[i] == BASE_EXPLODING) begin
            tmr_nx[i] = tmr[i] - TW'(1);
            if (tmr[i] == TW'(1)) begin
              bst_nx[i] = BASE_DEAD;
              tmr_nx[i] = TW'(RESPAWN_FRAMES);
            end
          end else if (bst[i] == BASE_DEAD && tmr[i] != '0) begin
            tmr_nx[i] = tmr[i] - TW'(1);
            if (tmr[i] == TW'(1)) bst_nx[i] = BASE_ALIVE;
          end
        end
      end
    end
    for (int i = 0; i < N_BASES; i++) begin
      alive_nx[i] = (bst_nx[i] == BASE_ALIVE);
      expl_nx[i]  = (bst_nx[i] == BASE_EXPLODING);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mgr            <= MGR_IDLE;
      idx            <= '0;
      snap_x         <= '0;
      snap_y         <= '0;
      snap_v         <= '0;
      consumed       <= '0;
      hit_mask       <= '0;
      bullet_kill    <= '0;
      score          <= SCORE_INIT;
      tick_overrun   <= 1'b0;
      base_alive     <= '1;
      base_exploding <= '0;
      all_cleared    <= 1'b0;
      for (int i = 0; i < N_BASES; i++) begin
        bst[i] <= BASE_ALIVE;
        tmr[i] <= '0;
      end
    end else begin
      bullet_kill    <= '0;
      base_alive     <= alive_nx;
      base_exploding <= expl_nx;
      all_cleared    <= ~|(alive_nx | expl_nx);
      for (int i = 0; i < N_BASES; i++) begin
        bst[i] <= bst_nx[i];
        tmr[i] <= tmr_nx[i];
      end
      case (mgr)
        MGR_IDLE: begin
          if (frame_tick) begin
            snap_x   <= bullet_x;
            snap_y   <= bullet_y;
            snap_v   <= bullet_valid;
            consumed <= '0;
            hit_mask <= '0;
            idx      <= '0;
            mgr      <= MGR_SCAN;
          end
        end
        MGR_SCAN: begin
          if (frame_tick) tick_overrun <= 1'b1;
          bullet_kill <= hits;
          consumed    <= consumed | hits;
          if (|hits) begin
            hit_mask[idx] <= 1'b1;
            score         <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          end
          if (idx == IW'(N_BASES - 1)) mgr <= MGR_UPDATE;
          else                         idx <= idx + IW'(1);
        end
        MGR_UPDATE: begin
          if (frame_tick) tick_overrun <= 1'b1;
          mgr <= MGR_IDLE;
        end
        default: mgr <= MGR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_base_manager.sv
// Directed bench for enemy_base_manager with a frame-level reference model checked every cycle.
module tb_enemy_base_manager;

  localparam int N     = 4;
  localparam int HALF  = 5;
  localparam int OFF_X = 32;
  localparam int OFF_Y = 36;
  localparam int EXPL  = 16;

  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic [10*N-1:0] tl_x, tl_y;
  logic [19:0] bx, by;
  logic [1:0]  bv;

  logic [1:0]   kill, kill2;
  logic [N-1:0] alive, expl, alive2, expl2;
  logic [15:0]  score, score2;
  logic cleared, busy, over, cleared2, busy2, over2;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  enemy_base_manager dut (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick),
    .base_tl_x(tl_x), .base_tl_y(tl_y),
    .bullet_x(bx), .bullet_y(by), .bullet_valid(bv),
    .bullet_kill(kill), .base_alive(alive), .base_exploding(expl),
    .score(score), .all_cleared(cleared), .scan_busy(busy), .tick_overrun(over)
  );

  enemy_base_manager #(.SCORE_INIT(16'hFFF8)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick),
    .base_tl_x(tl_x), .base_tl_y(tl_y),
    .bullet_x(bx), .bullet_y(by), .bullet_valid(bv),
    .bullet_kill(kill2), .base_alive(alive2), .base_exploding(expl2),
    .score(score2), .all_cleared(cleared2), .scan_busy(busy2), .tick_overrun(over2)
  );

  // ---- reference model: 0 = alive, 1 = exploding, 2 = dead ----
  int   m_st [N];
  int   m_tm [N];
  int   m_score = 0;
  int   m_phase = 0;
  bit   m_over  = 1'b0;
  logic [1:0] m_kill = 2'b00;
  logic [1:0] plan_kill [N];
  bit   plan_hit [N];

  function automatic bit in_window(input int i, input int b);
    int cx, cy, x, y;
    cx = int'(tl_x[10*i +: 10]) + OFF_X;
    cy = int'(tl_y[10*i +: 10]) + OFF_Y;
    x  = int'(bx[10*b +: 10]);
    y  = int'(by[10*b +: 10]);
    return (x - cx <= HALF) && (cx - x <= HALF) && (y - cy <= HALF) && (cy - y <= HALF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_tm[i] = 0; end
    m_score = 0; m_phase = 0; m_over = 1'b0; m_kill = 2'b00;
  endtask

  task automatic plan_frame();
    logic [1:0] used;
    used = 2'b00;
    for (int i = 0; i < N; i++) begin
      plan_kill[i] = 2'b00;
      if (m_st[i] == 0)
        for (int b = 0; b < 2; b++)
          if (bv[b] && !used[b] && in_window(i, b)) begin
            plan_kill[i][b] = 1'b1;
            used[b] = 1'b1;
          end
      plan_hit[i] = (plan_kill[i] != 2'b00);
    end
  endtask

  task automatic model_step();
    m_kill = 2'b00;
    if (m_phase == 0) begin
      if (frame_tick) begin plan_frame(); m_phase = 1; end
    end else begin
      if (frame_tick) m_over = 1'b1;
      if (m_phase <= N) begin
        if (plan_hit[m_phase-1]) begin
          m_st[m_phase-1] = 1;
          m_tm[m_phase-1] = EXPL;
          m_kill  = plan_kill[m_phase-1];
          m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        end
        m_phase++;
      end else begin
        for (int i = 0; i < N; i++)
          if (!plan_hit[i] && m_st[i] == 1) begin
            m_tm[i]--;
            if (m_tm[i] == 0) m_st[i] = 2;
          end
        m_phase = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] ea, ee;
    for (int i = 0; i < N; i++) begin
      ea[i] = (m_st[i] == 0);
      ee[i] = (m_st[i] == 1);
    end
    check("model_alive",   32'(alive),   32'(ea));
    check("model_explode", 32'(expl),    32'(ee));
    check("model_score",   32'(score),   32'(m_score));
    check("model_kill",    32'(kill),    32'(m_kill));
    check("model_cleared", 32'(cleared), 32'(~|(ea | ee)));
    check("model_busy",    32'(busy),    32'(m_phase != 0));
    check("model_overrun", 32'(over),    32'(m_over));
  end

  // ---- stimulus ----
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
  endtask

  task automatic frame();
    tick(); step(7);
  endtask

  task automatic set_bullet(input int b, input int x, input int y);
    bx[10*b +: 10] = 10'(x);
    by[10*b +: 10] = 10'(y);
  endtask

  initial begin
    tl_x = {10'd500, 10'd300, 10'd300, 10'd100};
    tl_y = {10'd300, 10'd100, 10'd100, 10'd100};
    bx = '0; by = '0; bv = 2'b00;
    step(3); rst_n = 1'b1; step(1);

    at_neg();
    check("reset_alive",   32'(alive),   32'hF);
    check("reset_explode", 32'(expl),    32'h0);
    check("reset_score",   32'(score),   32'h0);
    check("reset_kill",    32'(kill),    32'h0);
    check("reset_cleared", 32'(cleared), 32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_overrun", 32'(over),    32'h0);

    // Test 1: bullet 0 dead-centre on base 0.
    set_bullet(0, 132, 136); bv = 2'b01;
    step(1); tick();
    at_neg();
    check("t1_kill_T1", 32'(kill), 32'h0);
    check("t1_busy_T1", 32'(busy), 32'h1);
    step(1); at_neg();
    check("t1_kill_T2",  32'(kill),   32'h1);
    check("t1_score",    32'(score),  32'd10);
    check("t1_explode",  32'(expl),   32'h1);
    check("t1_alive",    32'(alive),  32'hE);
    check("t1_sat_score",32'(score2), 32'hFFFF);
    step(1); at_neg();
    check("t1_kill_T3", 32'(kill), 32'h0);
    bv = 2'b00; step(6);

    // Test 2: window edges on base 3 (centre 532,336).
    set_bullet(0, 538, 336); bv = 2'b01; frame();            // frame +1
    check("t2_miss_score", 32'(score), 32'd10);
    check("t2_miss_alive", 32'(alive[3]), 32'h1);
    tl_x[30 +: 10] = 10'd1000; set_bullet(0, 8, 336); frame(); // frame +2, centre 1032 must not wrap to 8
    check("t2_nowrap_alive", 32'(alive[3]), 32'h1);
    tl_x[30 +: 10] = 10'd500;
    set_bullet(0, 537, 341); frame();                          // frame +3
    check("t2_edge_score",   32'(score),   32'd20);
    check("t2_edge_explode", 32'(expl[3]), 32'h1);

    // Test 3: base 1 and base 2 share centre (332,136); the lower index wins.
    set_bullet(0, 332, 136); tick(); step(2); at_neg();       // frame +4
    check("t3_kill",    32'(kill), 32'h1);
    check("t3_explode", 32'(expl), 32'hB);
    step(6);
    check("t3_score", 32'(score), 32'd30);

    // Test 4: both bullets on base 2.
    set_bullet(1, 332, 136); bv = 2'b11; tick(); step(3); at_neg(); // frame +5
    check("t4_kill", 32'(kill), 32'h3);
    step(5);
    check("t4_score", 32'(score), 32'd40);
    bv = 2'b00;

    // Test 5: age explosions to death; no respawn.
    for (int f = 6; f <= 23; f++) begin
      frame();
      if (f == 15) check("t5_b0_still_exploding", 32'(expl[0]), 32'h1);
      if (f == 16) begin
        check("t5_b0_done",  32'(expl[0]),  32'h0);
        check("t5_b0_dead",  32'(alive[0]), 32'h0);
      end
      if (f == 20) check("t5_not_cleared", 32'(cleared), 32'h0);
      if (f == 21) check("t5_cleared",     32'(cleared), 32'h1);
    end
    check("t5_stay_dead", 32'(alive), 32'h0);

    // Test 6a: frame_tick during a scan.
    tick(); step(1); frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    at_neg();
    check("t6_overrun", 32'(over), 32'h1);
    step(8);
    check("t6_idle_after", 32'(busy), 32'h0);

    // Test 6b: reset asserted with a hit pending in the scan.
    rst_n = 1'b0; step(2); rst_n = 1'b1; step(1);
    set_bullet(0, 132, 136); bv = 2'b01; step(1);
    tick();
    rst_n = 1'b0;
    at_neg();
    check("t6_rst_kill",    32'(kill),  32'h0);
    check("t6_rst_alive",   32'(alive), 32'hF);
    check("t6_rst_busy",    32'(busy),  32'h0);
    check("t6_rst_score",   32'(score), 32'h0);
    check("t6_rst_overrun", 32'(over),  32'h0);
    step(2); bv = 2'b00; rst_n = 1'b1; step(10);
    check("t6_after_score", 32'(score), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
